// File: rtl/uart_link_ctrl_if.sv
// Link bundle between the UART link controller and its peripherals.
// Carries the receiver handshake (rx_ready/rx_data/rx_ready_clr), the
// transmitter handshake (tx_data/tx_wr_en/tx_busy) and the published
// drive command (cmd_valid/cmd/arg/failsafe) plus error reporting
// (frame_err/err_count).
//   master : the link controller (consumes rx bytes, drives tx and command)
//   slave  : the UART receiver/transmitter and command consumer side
interface uart_link_ctrl_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_ready_clr;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic       tx_busy;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       failsafe;
    logic       frame_err;
    logic [7:0] err_count;

    modport master (
        input  rx_ready, rx_data, tx_busy,
        output rx_ready_clr, tx_data, tx_wr_en,
        output cmd_valid, cmd, arg, failsafe, frame_err, err_count
    );

    modport slave (
        output rx_ready, rx_data, tx_busy,
        input  rx_ready_clr, tx_data, tx_wr_en,
        input  cmd_valid, cmd, arg, failsafe, frame_err, err_count
    );
endinterface

// File: rtl/uart_link_ctrl.sv
// Remote-control link sequencer for the car.
// Parses 4-byte frames {SYNC, CMD, ARG, CHK=CMD^ARG} from the UART receiver,
// publishes valid commands, answers ACK+CMD or NAK through the transmitter,
// and forces STOP_CMD when no valid frame arrives for WDOG_CYCLES.
// Ports:
//   clk_50m : system clock
//   clear   : asynchronous active-high reset
//   link    : uart_link_ctrl_if.master (rx/tx handshakes, command, errors)
module uart_link_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15,
    parameter logic [7:0]  STOP_CMD     = 8'h00,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter int unsigned WDOG_CYCLES  = 25000000
) (
    input logic            clk_50m,
    input logic            clear,
    uart_link_ctrl_if.master link
);
    localparam int unsigned TO_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT, GET_CMD, GET_ARG, GET_CHK, TX_LOAD, TX_HI, TX_LO
    } state_t;

    state_t state, state_nx;

    logic [TO_W-1:0] to_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic [7:0]      cmd_b, arg_b;
    logic [7:0]      q0, q1;
    logic [1:0]      q_cnt;

    logic       rx_clr_q, wr_q, valid_q, err_q, failsafe_q;
    logic [7:0] tx_data_q, cmd_q, arg_q, err_cnt_q;

    logic in_get, accept, to_hit, chk_ok, chk_bad, wd_hit, load;

    // State register
    always_ff @(posedge clk_50m or posedge clear) begin
        if (clear) state <= HUNT;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            HUNT:    if (accept && link.rx_data == SYNC_BYTE) state_nx = GET_CMD;
            GET_CMD: if (accept) state_nx = GET_ARG; else if (to_hit) state_nx = HUNT;
            GET_ARG: if (accept) state_nx = GET_CHK; else if (to_hit) state_nx = HUNT;
            GET_CHK: if (accept) state_nx = TX_LOAD; else if (to_hit) state_nx = HUNT;
            TX_LOAD: if (!link.tx_busy) state_nx = TX_HI;
            TX_HI:   if (link.tx_busy) state_nx = TX_LO;
            TX_LO:   if (!link.tx_busy) state_nx = (q_cnt != 2'd0) ? TX_LOAD : HUNT;
            default: state_nx = HUNT;
        endcase
    end

    // Output/event decode
    always_comb begin
        in_get  = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
        // rx_clr_q still high means the byte just taken is still showing ready
        accept  = (in_get || state == HUNT) && link.rx_ready && !rx_clr_q;
        // a byte landing on the timeout cycle wins over the timeout
        to_hit  = in_get && !accept && (to_cnt == TO_W'(BYTE_TIMEOUT - 1));
        chk_ok  = (state == GET_CHK) && accept && (link.rx_data == (cmd_b ^ arg_b));
        chk_bad = (state == GET_CHK) && accept && (link.rx_data != (cmd_b ^ arg_b));
        wd_hit  = (wd_cnt == WD_W'(WDOG_CYCLES - 1));
        load    = (state == TX_LOAD) && !link.tx_busy;
    end

    // Datapath, pulses, counters
    always_ff @(posedge clk_50m or posedge clear) begin
        if (clear) begin
            rx_clr_q   <= 1'b0;
            wr_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            failsafe_q <= 1'b1;
            tx_data_q  <= '0;
            cmd_q      <= STOP_CMD;
            arg_q      <= '0;
            err_cnt_q  <= '0;
            cmd_b      <= '0;
            arg_b      <= '0;
            q0         <= '0;
            q1         <= '0;
            q_cnt      <= '0;
            to_cnt     <= '0;
            wd_cnt     <= '0;
        end else begin
            rx_clr_q <= accept;
            wr_q     <= load;
            valid_q  <= chk_ok;
            err_q    <= chk_bad || to_hit;

            if ((chk_bad || to_hit) && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;

            if (accept && state == GET_CMD) cmd_b <= link.rx_data;
            if (accept && state == GET_ARG) arg_b <= link.rx_data;

            if (chk_ok) begin
                q0    <= ACK_BYTE;
                q1    <= cmd_b;
                q_cnt <= 2'd2;
            end else if (chk_bad) begin
                q0    <= NAK_BYTE;
                q_cnt <= 2'd1;
            end else if (load) begin
                tx_data_q <= q0;
                q0        <= q1;
                q_cnt     <= q_cnt - 2'd1;
            end

            if (in_get && !accept && !to_hit) to_cnt <= to_cnt + TO_W'(1);
            else                              to_cnt <= '0;

            if (chk_ok) begin
                wd_cnt     <= '0;
                failsafe_q <= 1'b0;
                cmd_q      <= cmd_b;
                arg_q      <= arg_b;
            end else begin
                if (wd_cnt != WD_W'(WDOG_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_hit) begin
                    failsafe_q <= 1'b1;
                    cmd_q      <= STOP_CMD;
                    arg_q      <= '0;
                end
            end
        end
    end

    assign link.rx_ready_clr = rx_clr_q;
    assign link.tx_wr_en     = wr_q;
    assign link.tx_data      = tx_data_q;
    assign link.cmd_valid    = valid_q;
    assign link.cmd          = cmd_q;
    assign link.arg          = arg_q;
    assign link.failsafe     = failsafe_q;
    assign link.frame_err    = err_q;
    assign link.err_count    = err_cnt_q;
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: a frame-level reference model pushes
// expected commands, transmitted bytes and error events; a monitor pops and
// compares whenever the DUT pulses cmd_valid, tx_wr_en or frame_err.
module tb_uart_link_ctrl;
    localparam int unsigned T_TO = 40;
    localparam int unsigned T_WD = 600;
    localparam logic [7:0]  SYNC = 8'hAA;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic clk_50m = 1'b0;
    logic clear   = 1'b1;

    uart_link_ctrl_if u();

    uart_link_ctrl #(.BYTE_TIMEOUT(T_TO), .WDOG_CYCLES(T_WD)) dut (
        .clk_50m(clk_50m),
        .clear  (clear),
        .link   (u)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct { logic [7:0] c; logic [7:0] a; } cmd_t;
    typedef struct { int unsigned cnt; bit is_to; } err_t;

    cmd_t        exp_cmd[$];
    logic [7:0]  exp_tx[$];
    err_t        exp_err[$];
    logic [7:0]  fbuf[$];
    int unsigned m_err = 0;

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned cyc = 0, last_clr_cyc = 0, last_valid_cyc = 0;
    int unsigned clr_count = 0, bytes_sent = 0;

    task automatic check(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model (frame level) ----------------
    function automatic void model_err(bit is_to);
        err_t e;
        m_err = (m_err >= 255) ? 255 : m_err + 1;
        e.cnt = m_err;
        e.is_to = is_to;
        exp_err.push_back(e);
    endfunction

    // Accept-to-accept distance is idle+1, but never below 2 (re-accept guard).
    function automatic void model_gap(int unsigned idle);
        int unsigned gap;
        gap = (idle == 0) ? 2 : idle + 1;
        if (fbuf.size() != 0 && gap > T_TO) begin
            fbuf.delete();
            model_err(1'b1);
        end
    endfunction

    function automatic void model_byte(logic [7:0] b);
        cmd_t c;
        if (fbuf.size() == 0) begin
            if (b == SYNC) fbuf.push_back(b);
        end else begin
            fbuf.push_back(b);
            if (fbuf.size() == 4) begin
                if ((fbuf[1] ^ fbuf[2]) == fbuf[3]) begin
                    c.c = fbuf[1];
                    c.a = fbuf[2];
                    exp_cmd.push_back(c);
                    exp_tx.push_back(ACK);
                    exp_tx.push_back(fbuf[1]);
                end else begin
                    model_err(1'b0);
                    exp_tx.push_back(NAK);
                end
                fbuf.delete();
            end
        end
    endfunction

    // ---------------- receiver driver ----------------
    task automatic send_byte(logic [7:0] b, int unsigned idle);
        model_gap(idle);
        repeat (idle) @(negedge clk_50m);
        model_byte(b);
        u.rx_data  = b;
        u.rx_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50m);
            if (u.rx_ready_clr) break;
        end
        check("rx_byte_cleared", u.rx_ready_clr, 1);
        u.rx_ready = 1'b0;
        bytes_sent++;
    endtask

    task automatic send_frame(logic [7:0] c, logic [7:0] a, logic [7:0] k);
        send_byte(SYNC, 0);
        send_byte(c, 0);
        send_byte(a, 0);
        send_byte(k, 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_50m);
            if (exp_cmd.size() == 0 && exp_tx.size() == 0 && exp_err.size() == 0 && !u.tx_busy)
                break;
        end
        check("scoreboard_drained", exp_cmd.size() + exp_tx.size() + exp_err.size(), 0);
        repeat (4) @(negedge clk_50m);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_rx_ready_clr"}, u.rx_ready_clr, 0);
        check({tag, "_tx_wr_en"},     u.tx_wr_en, 0);
        check({tag, "_tx_data"},      u.tx_data, 0);
        check({tag, "_cmd_valid"},    u.cmd_valid, 0);
        check({tag, "_frame_err"},    u.frame_err, 0);
        check({tag, "_err_count"},    u.err_count, 0);
        check({tag, "_cmd"},          u.cmd, 8'h00);
        check({tag, "_arg"},          u.arg, 0);
        check({tag, "_failsafe"},     u.failsafe, 1);
    endtask

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk_50m);
        cyc++;
    end

    // ---------------- transmitter model ----------------
    initial begin
        int unsigned busy_cnt;
        busy_cnt  = 0;
        u.tx_busy = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) u.tx_busy = 1'b0;
            end else if (u.tx_wr_en) begin
                u.tx_busy = 1'b1;
                busy_cnt  = $urandom_range(2, 6);
            end else if (!clear && $urandom_range(0, 15) == 0) begin
                u.tx_busy = 1'b1;
                busy_cnt  = $urandom_range(1, 3);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit   prev_clr, prev_valid;
        cmd_t c;
        err_t e;
        logic [7:0] t;
        prev_clr = 0;
        prev_valid = 0;
        forever begin
            @(negedge clk_50m);
            if (!clear) begin
                if (u.frame_err) begin
                    if (exp_err.size() == 0) check("unexpected_frame_err", 1, 0);
                    else begin
                        e = exp_err.pop_front();
                        check("err_count", u.err_count, e.cnt);
                        if (e.is_to) check("timeout_latency", cyc - last_clr_cyc, T_TO);
                    end
                end
                if (u.rx_ready_clr) begin
                    check("rx_clr_pulse_width", prev_clr, 0);
                    clr_count++;
                    last_clr_cyc = cyc;
                end
                if (u.cmd_valid) begin
                    check("cmd_valid_pulse_width", prev_valid, 0);
                    if (exp_cmd.size() == 0) check("unexpected_cmd_valid", 1, 0);
                    else begin
                        c = exp_cmd.pop_front();
                        check("cmd", u.cmd, c.c);
                        check("arg", u.arg, c.a);
                        check("failsafe_cleared", u.failsafe, 0);
                    end
                    last_valid_cyc = cyc;
                end
                if (u.tx_wr_en) begin
                    if (exp_tx.size() == 0) check("unexpected_tx_wr_en", 1, 0);
                    else begin
                        t = exp_tx.pop_front();
                        check("tx_data", u.tx_data, t);
                    end
                end
                prev_clr   = u.rx_ready_clr;
                prev_valid = u.cmd_valid;
            end else begin
                prev_clr   = 0;
                prev_valid = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] c, a, k;
        u.rx_ready = 1'b0;
        u.rx_data  = '0;
        clear      = 1'b1;
        repeat (3) @(negedge clk_50m);
        check_reset("por");
        clear = 1'b0;
        repeat (2) @(negedge clk_50m);

        // valid frame
        send_frame(8'h12, 8'h34, 8'h26);
        wait_drain();
        check("cmd_after_ok", u.cmd, 8'h12);

        // checksum failure leaves command untouched
        send_frame(8'h12, 8'h34, 8'h00);
        wait_drain();
        check("cmd_after_nak", u.cmd, 8'h12);
        check("arg_after_nak", u.arg, 8'h34);

        // leading junk discarded silently
        send_byte(8'h55, 0);
        send_frame(8'h01, 8'h02, 8'h03);
        wait_drain();
        check("cmd_after_junk", u.cmd, 8'h01);

        // byte timeout mid-frame, then recovery
        send_byte(SYNC, 0);
        send_byte(8'h07, 0);
        send_byte(SYNC, T_TO + 5);
        send_byte(8'h3C, 0);
        send_byte(8'h4D, 0);
        send_byte(8'h71, 0);
        wait_drain();
        check("err_count_after_timeout", u.err_count, m_err);

        // byte arriving exactly on the timeout cycle is still taken
        send_byte(SYNC, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, T_TO - 1);
        send_byte(8'h99, 0);
        wait_drain();
        check("cmd_after_edge_byte", u.cmd, 8'h5A);

        // watchdog expiry and recovery
        send_frame(8'h44, 8'h11, 8'h55);
        for (int i = 0; i < int'(T_WD) + 100; i++) begin
            @(negedge clk_50m);
            if (u.failsafe) break;
        end
        check("wdog_failsafe", u.failsafe, 1);
        check("wdog_latency", cyc - last_valid_cyc, T_WD);
        check("wdog_cmd_stop", u.cmd, 8'h00);
        check("wdog_arg_zero", u.arg, 0);
        send_frame(8'h23, 8'h45, 8'h66);
        wait_drain();
        check("failsafe_after_recovery", u.failsafe, 0);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            c = 8'($urandom);
            a = 8'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ a);
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA9)), $urandom_range(0, 3));
            send_byte(SYNC, $urandom_range(0, 3));
            send_byte(c, $urandom_range(0, 3));
            send_byte(a, ($urandom_range(0, 9) == 0) ? T_TO + 3 : $urandom_range(0, 3));
            send_byte(k, $urandom_range(0, 3));
        end
        wait_drain();

        // error counter saturation
        for (int f = 0; f < 260; f++) begin
            c = 8'($urandom);
            a = 8'($urandom);
            send_frame(c, a, c ^ a ^ 8'h01);
        end
        wait_drain();
        check("err_count_saturated", u.err_count, 255);

        // reset while the ACK is on the wire discards the pending echo byte
        send_frame(8'h21, 8'h43, 8'h62);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50m);
            if (u.tx_wr_en) break;
        end
        check("tx_started_before_reset", u.tx_wr_en, 1);
        #2 clear = 1'b1;
        #1 check_reset("mid_tx");
        exp_tx.delete();
        fbuf.delete();
        m_err = 0;
        repeat (2) @(negedge clk_50m);
        clear = 1'b0;
        repeat (30) @(negedge clk_50m);
        send_frame(8'h0F, 8'hF0, 8'hFF);
        wait_drain();
        check("cmd_after_reset_frame", u.cmd, 8'h0F);
        check("rx_clr_count", clr_count, bytes_sent);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
